nmos_pmos: RTL and testbench

Clocked 4-bit register-file calculator whose combinational datapath (ALU, write decoder, read multiplexer) is built from `nmos`/`pmos` switch-level CMOS gate cells. It holds four 4-bit registers. Each falling clock edge it writes one ALU result into a register. The ALU combines the register selected by `rd_addr` with a 4-bit immediate. It is the top-level compute block of the CMOS-gate datapath.

---
 rtl/nmos_pmos.sv | 142 ++++++++++++++
 tb/tb_nmos_pmos.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/nmos_pmos.sv
// Four-register 4-bit calculator: ALU on R[rd_addr] and an immediate, result written on each falling clk edge.
// Define NMOS_PMOS_SWITCH_LEVEL_EN to build the combinational datapath from nmos/pmos switch cells.

`ifdef NMOS_PMOS_SWITCH_LEVEL_EN
module np_inv (output wire y, input wire a);
    supply1 vdd;
    supply0 gnd;
    pmos p0 (y, vdd, a);
    nmos n0 (y, gnd, a);
endmodule

module np_nand2 (output wire y, input wire a, input wire b);
    supply1 vdd;
    supply0 gnd;
    wire mid;
    pmos p0 (y, vdd, a);
    pmos p1 (y, vdd, b);
    nmos n0 (y, mid, a);
    nmos n1 (mid, gnd, b);
endmodule

module np_nor2 (output wire y, input wire a, input wire b);
    supply1 vdd;
    supply0 gnd;
    wire mid;
    pmos p0 (mid, vdd, a);
    pmos p1 (y, mid, b);
    nmos n0 (y, gnd, a);
    nmos n1 (y, gnd, b);
endmodule

module np_and2 (output wire y, input wire a, input wire b);
    wire t;
    np_nand2 u_n (.y(t), .a(a), .b(b));
    np_inv   u_i (.y(y), .a(t));
endmodule

module np_or2 (output wire y, input wire a, input wire b);
    wire t;
    np_nor2 u_n (.y(t), .a(a), .b(b));
    np_inv  u_i (.y(y), .a(t));
endmodule

module np_xor2 (output wire y, input wire a, input wire b);
    wire n1, n2, n3;
    np_nand2 u0 (.y(n1), .a(a),  .b(b));
    np_nand2 u1 (.y(n2), .a(a),  .b(n1));
    np_nand2 u2 (.y(n3), .a(b),  .b(n1));
    np_nand2 u3 (.y(y),  .a(n2), .b(n3));
endmodule

// y = s ? b : a
module np_mux2 (output wire y, input wire a, input wire b, input wire s);
    wire ns, t0, t1;
    np_inv   u0 (.y(ns), .a(s));
    np_nand2 u1 (.y(t0), .a(a),  .b(ns));
    np_nand2 u2 (.y(t1), .a(b),  .b(s));
    np_nand2 u3 (.y(y),  .a(t0), .b(t1));
endmodule
`endif

module nmos_pmos (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] rd_addr,
    input  logic [3:0] immediate,
    input  logic [1:0] we_addr,
    input  logic [2:0] control,
    output logic [3:0] rd_data
);
    logic [3:0] regs [4];
    logic [3:0] b_mux;
    logic [3:0] sum;
    logic [3:0] result;
    logic [3:0] we_dec;
    logic       slt;

`ifdef NMOS_PMOS_SWITCH_LEVEL_EN
    wire [4:0] carry;
    wire [3:0] and_r, or_r, slt_vec, m_lo, m_hi, r_lo, r_hi;
    wire [3:0] half, gen_n, prop_n;
    wire       n_imm3, slt_t1, slt_t2, slt_t3, n_we0, n_we1;

    assign carry[0] = control[2];
    assign slt_vec  = {3'b000, slt};

    for (genvar j = 0; j < 4; j++) begin : g_bit
        np_mux2  u_rm0 (.y(m_lo[j]), .a(regs[0][j]), .b(regs[1][j]), .s(rd_addr[0]));
        np_mux2  u_rm1 (.y(m_hi[j]), .a(regs[2][j]), .b(regs[3][j]), .s(rd_addr[0]));
        np_mux2  u_rm2 (.y(rd_data[j]), .a(m_lo[j]), .b(m_hi[j]), .s(rd_addr[1]));
        np_xor2  u_bx  (.y(b_mux[j]), .a(immediate[j]), .b(control[2]));
        np_xor2  u_h   (.y(half[j]), .a(rd_data[j]), .b(b_mux[j]));
        np_xor2  u_s   (.y(sum[j]), .a(half[j]), .b(carry[j]));
        np_nand2 u_g   (.y(gen_n[j]), .a(rd_data[j]), .b(b_mux[j]));
        np_nand2 u_p   (.y(prop_n[j]), .a(half[j]), .b(carry[j]));
        np_nand2 u_c   (.y(carry[j+1]), .a(gen_n[j]), .b(prop_n[j]));
        np_and2  u_and (.y(and_r[j]), .a(rd_data[j]), .b(b_mux[j]));
        np_or2   u_or  (.y(or_r[j]), .a(rd_data[j]), .b(b_mux[j]));
        np_mux2  u_o0  (.y(r_lo[j]), .a(and_r[j]), .b(or_r[j]), .s(control[0]));
        np_mux2  u_o1  (.y(r_hi[j]), .a(sum[j]), .b(slt_vec[j]), .s(control[0]));
        np_mux2  u_o2  (.y(result[j]), .a(r_lo[j]), .b(r_hi[j]), .s(control[1]));
    end

    np_inv  u_ni  (.y(n_imm3), .a(immediate[3]));
    np_and2 u_sl1 (.y(slt_t1), .a(rd_data[3]), .b(n_imm3));
    np_or2  u_sl2 (.y(slt_t2), .a(rd_data[3]), .b(n_imm3));
    np_and2 u_sl3 (.y(slt_t3), .a(sum[3]), .b(slt_t2));
    np_or2  u_sl4 (.y(slt), .a(slt_t1), .b(slt_t3));

    np_inv  u_nw0 (.y(n_we0), .a(we_addr[0]));
    np_inv  u_nw1 (.y(n_we1), .a(we_addr[1]));
    np_and2 u_d0  (.y(we_dec[0]), .a(n_we1), .b(n_we0));
    np_and2 u_d1  (.y(we_dec[1]), .a(n_we1), .b(we_addr[0]));
    np_and2 u_d2  (.y(we_dec[2]), .a(we_addr[1]), .b(n_we0));
    np_and2 u_d3  (.y(we_dec[3]), .a(we_addr[1]), .b(we_addr[0]));
`else
    assign rd_data = regs[rd_addr];
    assign b_mux   = control[2] ? ~immediate : immediate;
    assign sum     = rd_data + b_mux + {3'b000, control[2]};
    // uses raw immediate[3] so control=111 gives a signed less-than
    assign slt     = (rd_data[3] & ~immediate[3]) | (sum[3] & (rd_data[3] | ~immediate[3]));
    assign we_dec  = 4'b0001 << we_addr;

    always_comb begin
        result = 4'b0000;
        case (control[1:0])
            2'b00:   result = rd_data & b_mux;
            2'b01:   result = rd_data | b_mux;
            2'b10:   result = sum;
            default: result = {3'b000, slt};
        endcase
    end
`endif

    always_ff @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) if (we_dec[i]) regs[i] <= result;
        end
    end
endmodule

// File: tb/tb_nmos_pmos.sv
// Self-checking bench for nmos_pmos: vector table, hand sequences and a random model run via a scoreboard queue.
module tb_nmos_pmos;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rd_addr = 2'd0;
    logic [3:0] immediate = 4'd0;
    logic [1:0] we_addr = 2'd0;
    logic [2:0] control = 3'd0;
    logic [3:0] rd_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] sb [$];
    logic [3:0] model [4];

    typedef struct {
        logic       rst;
        logic [1:0] rd;
        logic [3:0] imm;
        logic [1:0] we;
        logic [2:0] ctrl;
        logic [1:0] chk;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [14];

    nmos_pmos dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .immediate(immediate),
        .we_addr(we_addr), .control(control), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d compares, required completion", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic r, input logic [1:0] rd, input logic [3:0] imm,
                                input logic [1:0] we, input logic [2:0] ctrl,
                                input logic [1:0] chk, input logic [3:0] exp);
        vec_t v;
        v.rst = r; v.rd = rd; v.imm = imm; v.we = we; v.ctrl = ctrl; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] imm, input logic [2:0] ctrl);
        logic [3:0] b, s;
        logic lt;
        b  = ctrl[2] ? ~imm : imm;
        s  = a + b + {3'b000, ctrl[2]};
        lt = (a[3] & ~imm[3]) | (s[3] & (a[3] | ~imm[3]));
        case (ctrl[1:0])
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return s;
            default: return {3'b000, lt};
        endcase
    endfunction

    task automatic check(input string name, input logic [3:0] req);
        n_cmp++;
        if (rd_data !== req) begin
            n_bad++;
            $display("FAIL %s: rd_data=%0d required=%0d (t=%0t)", name, rd_data, req, $time);
        end
    endtask

    // Drive while clk is high, capture on the falling edge, then read back register chk.
    task automatic apply(input string name, input logic r, input logic [1:0] rd, input logic [3:0] imm,
                         input logic [1:0] we, input logic [2:0] ctrl,
                         input logic [1:0] chk, input logic [3:0] exp);
        @(posedge clk); #1;
        rst = r; rd_addr = rd; immediate = imm; we_addr = we; control = ctrl;
        sb.push_back(exp);
        @(negedge clk); #1;
        rd_addr = chk;
        #1;
        check(name, sb.pop_front());
    endtask

    initial begin
        vecs[0]  = mk(1'b0, 2'd0, 4'd5, 2'd0, 3'b010, 2'd0, 4'd5);
        vecs[1]  = mk(1'b0, 2'd0, 4'd5, 2'd0, 3'b010, 2'd0, 4'd10);
        vecs[2]  = mk(1'b0, 2'd0, 4'd9, 2'd0, 3'b010, 2'd0, 4'd3);
        vecs[3]  = mk(1'b0, 2'd0, 4'd2, 2'd0, 3'b010, 2'd0, 4'd5);
        vecs[4]  = mk(1'b0, 2'd0, 4'd3, 2'd1, 3'b001, 2'd1, 4'd7);
        vecs[5]  = mk(1'b0, 2'd0, 4'd3, 2'd2, 3'b000, 2'd2, 4'd1);
        vecs[6]  = mk(1'b0, 2'd0, 4'd0, 2'd3, 3'b000, 2'd0, 4'd5);
        vecs[7]  = mk(1'b0, 2'd0, 4'd7, 2'd3, 3'b110, 2'd3, 4'd14);
        vecs[8]  = mk(1'b0, 2'd0, 4'd7, 2'd1, 3'b111, 2'd1, 4'd1);
        vecs[9]  = mk(1'b0, 2'd3, 4'd3, 2'd2, 3'b111, 2'd2, 4'd1);
        vecs[10] = mk(1'b0, 2'd0, 4'd8, 2'd1, 3'b111, 2'd1, 4'd0);
        vecs[11] = mk(1'b0, 2'd2, 4'd2, 2'd2, 3'b001, 2'd2, 4'd3);
        vecs[12] = mk(1'b0, 2'd2, 4'd3, 2'd1, 3'b111, 2'd1, 4'd0);
        vecs[13] = mk(1'b0, 2'd0, 4'd7, 2'd3, 3'b011, 2'd3, 4'd1);

        // reset after arbitrary writes clears every register
        apply("init_reset", 1'b1, 2'd0, 4'd0, 2'd0, 3'b000, 2'd0, 4'd0);
        apply("pre_w1", 1'b0, 2'd0, 4'd9, 2'd1, 3'b010, 2'd1, 4'd9);
        apply("pre_w2", 1'b0, 2'd1, 4'd6, 2'd2, 3'b001, 2'd2, 4'd15);
        apply("pre_w3", 1'b0, 2'd2, 4'd0, 2'd3, 3'b110, 2'd3, 4'd15);
        apply("reset_edge", 1'b1, 2'd3, 4'd1, 2'd3, 3'b010, 2'd3, 4'd0);
        for (int a = 0; a < 4; a++) begin
            rd_addr = a[1:0];
            #1;
            check($sformatf("reset_read_r%0d", a), 4'd0);
        end

        for (int i = 0; i < 14; i++)
            apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].rd, vecs[i].imm,
                  vecs[i].we, vecs[i].ctrl, vecs[i].chk, vecs[i].exp);

        // reset mid-accumulate overrides the pending add, then operation resumes
        apply("mid_reset_clr", 1'b1, 2'd0, 4'd0, 2'd0, 3'b000, 2'd0, 4'd0);
        apply("mid_acc1", 1'b0, 2'd0, 4'd5, 2'd0, 3'b010, 2'd0, 4'd5);
        apply("mid_acc2", 1'b0, 2'd0, 4'd5, 2'd0, 3'b010, 2'd0, 4'd10);
        @(posedge clk); #1;
        rst = 1'b1; rd_addr = 2'd0; immediate = 4'd5; we_addr = 2'd0; control = 3'b010;
        #1;
        check("rise_no_effect", 4'd10);
        @(negedge clk); #1;
        check("mid_reset_r0", 4'd0);
        apply("mid_resume", 1'b0, 2'd0, 4'd5, 2'd0, 3'b010, 2'd0, 4'd5);

        // random run against a spec-level model
        for (int a = 0; a < 4; a++) model[a] = 4'd0;
        model[0] = 4'd5;
        for (int i = 0; i < 60; i++) begin
            logic [1:0] rd, we;
            logic [3:0] imm, res;
            logic [2:0] ctrl;
            logic r;
            rd   = 2'($urandom_range(0, 3));
            we   = 2'($urandom_range(0, 3));
            imm  = 4'($urandom_range(0, 15));
            ctrl = 3'($urandom_range(0, 7));
            r    = ($urandom_range(0, 19) == 0);
            res  = alu(model[rd], imm, ctrl);
            if (r) for (int a = 0; a < 4; a++) model[a] = 4'd0;
            else   model[we] = res;
            apply($sformatf("rand%0d", i), r, rd, imm, we, ctrl, we, model[we]);
        end

        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
